// File: rtl/sha256_round_engine.sv
// Iterative SHA-256 compression engine, one round per clock, round constant supplied externally.
// Optional SHA256_ROUND_ENGINE_ABORT_EN adds an abort input that drops an in-flight block.
module sha256_round_engine (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [511:0] block_in,
  input  logic [255:0] h_in,
  output logic [5:0]   round,
  input  logic [31:0]  k_const,
`ifdef SHA256_ROUND_ENGINE_ABORT_EN
  input  logic         abort,
`endif
  output logic         busy,
  output logic         done,
  output logic [255:0] digest_out
);

  localparam int unsigned ROUNDS = 64;
  localparam int unsigned RND_W  = 6;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned WIN_N  = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROUNDS = 2'd1,
    S_FINAL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [RND_W-1:0]    round_q, round_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [255:0]        digest_q, digest_d;
  logic [255:0]        hreg_q, hreg_d;
  logic [WORD_W-1:0]   a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
  logic [WORD_W-1:0]   a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d;
  logic [WORD_W-1:0]   w_q [WIN_N];
  logic [WORD_W-1:0]   w_d [WIN_N];

  logic [WORD_W-1:0]   t1, t2, w_new;
  logic                abort_hit;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Round datapath: compression terms and the next schedule word.
  always_comb begin
    t1    = h_q + bsig1(e_q) + ((e_q & f_q) ^ (~e_q & g_q)) + k_const + w_q[0];
    t2    = bsig0(a_q) + ((a_q & b_q) ^ (a_q & c_q) ^ (b_q & c_q));
    w_new = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
  end

`ifdef SHA256_ROUND_ENGINE_ABORT_EN
  assign abort_hit = abort && (state_q != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    digest_d = digest_q;
    hreg_d   = hreg_q;
    a_d = a_q; b_d = b_q; c_d = c_q; d_d = d_q;
    e_d = e_q; f_d = f_q; g_d = g_q; h_d = h_q;
    w_d = w_q;

    if (abort_hit) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      round_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            hreg_d = h_in;
            a_d = h_in[255:224]; b_d = h_in[223:192];
            c_d = h_in[191:160]; d_d = h_in[159:128];
            e_d = h_in[127:96];  f_d = h_in[95:64];
            g_d = h_in[63:32];   h_d = h_in[31:0];
            for (int i = 0; i < int'(WIN_N); i++) begin
              w_d[i] = block_in[32*(15-i) +: 32];
            end
            round_d = '0;
            busy_d  = 1'b1;
            state_d = S_ROUNDS;
          end
        end
        S_ROUNDS: begin
          h_d = g_q; g_d = f_q; f_d = e_q; e_d = d_q + t1;
          d_d = c_q; c_d = b_q; b_d = a_q; a_d = t1 + t2;
          for (int i = 0; i < int'(WIN_N) - 1; i++) begin
            w_d[i] = w_q[i+1];
          end
          w_d[WIN_N-1] = w_new;
          round_d = round_q + RND_W'(1);
          if (round_q == RND_W'(ROUNDS - 1)) begin
            state_d = S_FINAL;
          end
        end
        S_FINAL: begin
          digest_d = {hreg_q[255:224] + a_q, hreg_q[223:192] + b_q,
                      hreg_q[191:160] + c_q, hreg_q[159:128] + d_q,
                      hreg_q[127:96]  + e_q, hreg_q[95:64]   + f_q,
                      hreg_q[63:32]   + g_q, hreg_q[31:0]    + h_q};
          done_d  = 1'b1;
          busy_d  = 1'b0;
          round_d = '0;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          round_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      round_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      digest_q <= '0;
      hreg_q   <= '0;
      a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0;
      e_q <= '0; f_q <= '0; g_q <= '0; h_q <= '0;
      for (int i = 0; i < int'(WIN_N); i++) begin
        w_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      digest_q <= digest_d;
      hreg_q   <= hreg_d;
      a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d;
      e_q <= e_d; f_q <= f_d; g_q <= g_d; h_q <= h_d;
      for (int i = 0; i < int'(WIN_N); i++) begin
        w_q[i] <= w_d[i];
      end
    end
  end

  assign round      = round_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign digest_out = digest_q;

endmodule

// File: tb/tb_sha256_round_engine.sv
// Bench for sha256_round_engine: known-answer vectors plus random blocks against a plain SHA-256 model.
// Exercises abort when SHA256_ROUND_ENGINE_ABORT_EN is defined.
module tb_sha256_round_engine;

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMP = {32'h80000000, 480'h0};
  localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMP = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [511:0] block_in;
  logic [255:0] h_in;
  logic [5:0]   round;
  logic [31:0]  k_const;
  logic         busy;
  logic         done;
  logic [255:0] digest_out;
`ifdef SHA256_ROUND_ENGINE_ABORT_EN
  logic         abort;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign k_const = K_TAB[round];

  sha256_round_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .block_in   (block_in),
    .h_in       (h_in),
    .round      (round),
    .k_const    (k_const),
`ifdef SHA256_ROUND_ENGINE_ABORT_EN
    .abort      (abort),
`endif
    .busy       (busy),
    .done       (done),
    .digest_out (digest_out)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 compression: full 64-word schedule, then 64 rounds, then feed-forward.
  function automatic logic [255:0] ref_compress(input logic [511:0] blk, input logic [255:0] hin);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] hv [8];
    logic [31:0] s0, s1, t1, t2;
    logic [255:0] res;
    for (int i = 0; i < 8; i++) hv[i] = hin[255 - 32*i -: 32];
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = hv[i];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TAB[i] + w[i];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hv[i] + v[i];
    return res;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Runs one job from IDLE; optionally pokes a second start at round poke_at.
  task automatic run_job(input string tag, input logic [511:0] blk, input logic [255:0] hin,
                         input int poke_at, output logic [255:0] dig);
    logic [255:0] prev;
    bit seq_ok, held;
    int lat, exp_r;
    prev = digest_out; seq_ok = 1; held = 1;
    block_in = blk; h_in = hin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; block_in = rnd512(); h_in = rnd256();
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      exp_r = (lat <= 64) ? lat - 1 : 0;
      if (round !== 6'(exp_r) || busy !== 1'b1) seq_ok = 0;
      if (digest_out !== prev) held = 0;
      if (poke_at >= 0 && lat <= 64 && int'(round) == poke_at) begin
        start = 1'b1; block_in = rnd512();
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 256'(lat), 256'd66);
    check({tag, "_round_seq"}, 256'(seq_ok), 256'd1);
    check({tag, "_digest_hold"}, 256'(held), 256'd1);
    check({tag, "_busy_at_done"}, 256'(busy), 256'd0);
    dig = digest_out;
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, 256'(done), 256'd0);
  endtask

  initial begin
    logic [255:0] dig;
    logic [511:0] blk;
    logic [255:0] hin;
    bit quiet;
    int n;
    rst_n = 1'b0; start = 1'b0; block_in = '0; h_in = '0;
`ifdef SHA256_ROUND_ENGINE_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 256'(busy), 256'd0);
    check("rst_done", 256'(done), 256'd0);
    check("rst_round", 256'(round), 256'd0);
    check("rst_digest", digest_out, 256'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_job("abc", BLK_ABC, IV, -1, dig);
    check("abc_digest", dig, DIG_ABC);

    run_job("empty", BLK_EMP, IV, -1, dig);
    check("empty_digest", dig, DIG_EMP);

    for (int t = 0; t < 4; t++) begin
      blk = rnd512(); hin = rnd256();
      run_job("rand", blk, hin, -1, dig);
      check("rand_digest", dig, ref_compress(blk, hin));
    end

    // Start while busy must be ignored and must not queue a job.
    run_job("poke", BLK_ABC, IV, 10, dig);
    check("poke_digest", dig, DIG_ABC);
    quiet = 1;
    repeat (80) begin
      if (done !== 1'b0 || busy !== 1'b0) quiet = 0;
      @(posedge clk); #1;
    end
    check("poke_no_queue", 256'(quiet), 256'd1);

    // Asynchronous reset mid-job.
    block_in = BLK_EMP; h_in = IV; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; n = 0;
    while (round !== 6'd30 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("reach_round30", 256'(round), 256'd30);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 256'(busy), 256'd0);
    check("arst_done", 256'(done), 256'd0);
    check("arst_round", 256'(round), 256'd0);
    check("arst_digest", digest_out, 256'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_job("post_rst", BLK_ABC, IV, -1, dig);
    check("post_rst_digest", dig, DIG_ABC);

`ifdef SHA256_ROUND_ENGINE_ABORT_EN
    block_in = BLK_EMP; h_in = IV; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; n = 0;
    while (round !== 6'd40 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("reach_round40", 256'(round), 256'd40);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", 256'(busy), 256'd0);
    check("abort_round", 256'(round), 256'd0);
    quiet = 1;
    repeat (70) begin
      if (done !== 1'b0 || busy !== 1'b0) quiet = 0;
      @(posedge clk); #1;
    end
    check("abort_no_done", 256'(quiet), 256'd1);
    check("abort_digest_kept", digest_out, DIG_ABC);
    run_job("post_abort", BLK_EMP, IV, -1, dig);
    check("post_abort_digest", dig, DIG_EMP);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_round_engine.md
Name: sha256_round_engine

Overview:
- Iterative SHA-256 compression engine; one round per clock.
- Drives the 6-bit round index to the round-constant lookup and consumes its 32-bit constant combinationally in the same cycle.
- Takes one 512-bit message block and a 256-bit chaining state; produces the 256-bit updated state.
- Sits between the miner's block/nonce assembly logic (upstream) and the digest compare/second-hash stage (downstream).

Parameters:
- ROUNDS, 64, number of compression rounds; fixed at 64 for SHA-256, and the index width stays 6 bits.

Ports:
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  start request; accepted only in IDLE
- block_in  input  512  message block; [511:480] = W0 … [31:0] = W15
- h_in  input  256  chaining state; [255:224] = H0 (a) … [31:0] = H7 (h)
- round  output  6  current round index, to constant lookup
- k_const  input  32  round constant for `round`, valid same cycle
- busy  output  1  high from the cycle after acceptance through FINAL
- done  output  1  one-cycle pulse when digest_out is updated
- digest_out  output  256  h_in + compressed state, word-wise mod 2^32; same ordering as h_in

Behaviour:
- Reset values:
  - FSM = IDLE; round = 0; busy = 0; done = 0; digest_out = 0.
  - Working registers a..h, the 16-word schedule window and the latched h_in are all cleared.
- States:
  - IDLE: start=1 at edge N latches h_in into a..h and into the H register, loads W0..W15 into the window, sets round=0, moves to ROUNDS.
  - ROUNDS: lasts 64 cycles with round = 0..63. At each edge:
    - T1 = h + Σ1(e) + Ch(e,f,g) + k_const + w[0].
    - T2 = Σ0(a) + Maj(a,b,c).
    - Rotate: h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2.
    - Window shifts down one word; the new w[15] = σ1(w[14]) + w[9] + σ0(w[1]) + w[0].
    - round increments. The edge with round=63 moves to FINAL.
  - FINAL: one cycle. At its closing edge, digest_out ← {H0+a, …, H7+h}, done←1 for exactly one cycle, state → IDLE, round←0.
- Arithmetic: all additions are 32-bit, wrap modulo 2^32, carries discarded.
  - Σ0 = ROTR2^ROTR13^ROTR22
  - Σ1 = ROTR6^ROTR11^ROTR25
  - σ0 = ROTR7^ROTR18^SHR3
  - σ1 = ROTR17^ROTR19^SHR10
- Timing: start sampled at edge N → busy high during cycles N+1..N+65 → done high during cycle N+66.
  - 66 edges from acceptance to digest; done coincides with busy=0, so a new start is acceptable in that same cycle.
- round is a registered output; k_const must be settled for the current round value within the same cycle.
- Boundary conditions:
  - start while busy (including FINAL): ignored, no queuing.
  - block_in/h_in changing after acceptance: no effect.
  - digest_out holds its value until the next FINAL. It is not cleared by a new start.
  - rst_n low at any point: immediate return to reset values. An in-flight block is lost and no done is produced.

Optional Feature:
- Macro SHA256_ROUND_ENGINE_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 at any edge while busy → next state IDLE, busy=0, round=0, no done; digest_out unchanged.
  - abort has priority over a round or FINAL update in the same cycle. It is ignored in IDLE; start and abort together in IDLE → start is accepted.
- Undefined: no abort port; every accepted block runs to completion.

Test Plan:
- "abc" digest:
  - Stimulus: h_in = IV 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19; block = 61626380, 13×00000000, 00000000, 00000018; start one cycle.
  - Required: done exactly 66 edges later; digest_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty string digest:
  - Stimulus: same IV; block = 80000000 followed by 15 zero words.
  - Required: digest_out = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Round sequencing: observe round during a job → 0,1,…,63 on consecutive busy cycles, then 0 during FINAL.
- Start while busy: pulse start at round 10 with a different block → ignored; "abc" digest still produced; next done only after a fresh start in IDLE.
- Reset mid-operation: assert rst_n=0 asynchronously at round 30 → busy, done, round and digest_out read 0 immediately. Then release reset and run "abc" → correct digest.
- Abort (SHA256_ROUND_ENGINE_ABORT_EN defined): complete "abc", then start the empty-string block and abort at round 40 → busy=0 next cycle, no done pulse, digest_out still the "abc" value.
